// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WR_DATA,
    ACK_DATA,
    RD_DATA,
    MACK,
    WAIT_STOP
  } state_e;

  localparam int BYTE_BITS = 8;
  localparam int ACK_BIT   = 9;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and decodes SCL edges and START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  // Flops reset high so an idle bus produces no spurious edges on reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise_o  =  scl_s & ~scl_hist_q;
  assign scl_fall_o  = ~scl_s &  scl_hist_q;
  assign start_det_o =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det_o  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;
  assign sda_o       =  sda_s;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target whose 7-bit address field indexes an internal byte register file;
// writes store data bytes, reads return stored bytes with auto-increment.
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr
);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_o      (sda)
  );

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        mem_q [2**ADDR_W];
  logic              mem_we;
  logic [7:0]        rd_byte;

  assign rd_byte = mem_q[addr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    mem_we     = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda};
            cnt_d   = cnt_q + 4'd1;
            // Eighth bit is R/W; the seven bits already shifted form the address.
            if (cnt_q == 4'(BYTE_BITS - 1)) begin
              addr_d = shift_q[ADDR_W-1:0];
              rw_d   = sda;
            end
          end else if (scl_fall && cnt_q == 4'(BYTE_BITS)) begin
            state_d  = ACK_ADDR;
            cnt_d    = 4'(ACK_BIT);
            sda_oe_d = 1'b1;
          end
        end
        ACK_ADDR: begin
          if (scl_fall && cnt_q == 4'(ACK_BIT)) begin
            if (rw_q) begin
              state_d    = RD_DATA;
              shift_d    = {rd_byte[6:0], 1'b0};
              sda_oe_d   = ~rd_byte[7];
              cnt_d      = 4'd1;
              rd_valid_d = 1'b1;
              rd_addr_d  = addr_q;
            end else begin
              state_d  = WR_DATA;
              cnt_d    = '0;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'(BYTE_BITS)) begin
            state_d  = ACK_DATA;
            cnt_d    = 4'(ACK_BIT);
            sda_oe_d = 1'b1;
          end
        end
        ACK_DATA: begin
          if (scl_fall && cnt_q == 4'(ACK_BIT)) begin
            state_d    = WR_DATA;
            cnt_d      = '0;
            sda_oe_d   = 1'b0;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = shift_q;
            mem_we     = 1'b1;
            addr_d     = addr_q + 1'b1;
          end
        end
        RD_DATA: begin
          // cnt_q counts bits already driven; the fall after bit 0 releases SDA.
          if (scl_fall) begin
            if (cnt_q == 4'(BYTE_BITS)) begin
              state_d  = MACK;
              cnt_d    = 4'(ACK_BIT);
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda) state_d = WAIT_STOP;
            else     addr_d  = addr_q + 1'b1;
          end else if (scl_fall) begin
            state_d    = RD_DATA;
            shift_d    = {rd_byte[6:0], 1'b0};
            sda_oe_d   = ~rd_byte[7];
            cnt_d      = 4'd1;
            rd_valid_d = 1'b1;
            rd_addr_d  = addr_q;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Register file comes out of reset holding its own index in every location.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= 8'(i);
    end else if (mem_we) begin
      mem_q[addr_q] <= shift_q;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed bench: a bit-banged I2C master drives the target and checks bus and pulse outputs.
module tb_i2c_target_mem;
  import i2c_pkg::*;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_valid, rd_valid;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [6:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  logic [6:0] last_rd_addr = '0;
  logic [7:0] rb;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_mem #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_valid(rd_valid),
    .rd_addr (rd_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (rd_valid) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= rd_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl = 1'b1; tick(2*Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    chk(tag, 32'(sda_oe), 32'd1);
    tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q);
      scl = 1'b1;   tick(Q);
      b[i] = sda_line;
      tick(Q);
      scl = 1'b0;   tick(Q);
    end
    send_bit(nack);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", {30'd0, wr_valid, rd_valid}, 32'd0);
    chk("rst_regs", {10'd0, wr_addr, wr_data, rd_addr}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Read after reset: address 0x07 returns its index
    i2c_start();
    chk("start_busy", 32'(busy), 32'd1);
    write_byte(8'h0F, "rd07_addr_ack");
    read_byte(1'b1, rb);
    chk("rd07_data", 32'(rb), 32'h07);
    chk("rd07_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("rd07_rd_addr", 32'(last_rd_addr), 32'h07);
    chk("rd07_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
    i2c_stop();
    chk("rd07_busy_off", 32'(busy), 32'd0);
    chk("rd07_idle", 32'(dut.state_q), 32'(IDLE));

    // Single write of 0x5A to 0x12, then read it back
    i2c_start();
    write_byte(8'h24, "wr12_addr_ack");
    write_byte(8'h5A, "wr12_data_ack");
    i2c_stop();
    chk("wr12_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("wr12_wr_addr", 32'(last_wr_addr), 32'h12);
    chk("wr12_wr_data", 32'(last_wr_data), 32'h5A);
    i2c_start();
    write_byte(8'h25, "rd12_addr_ack");
    read_byte(1'b1, rb);
    i2c_stop();
    chk("rd12_data", 32'(rb), 32'h5A);

    // Burst write across the address wrap, then burst read
    i2c_start();
    write_byte(8'hFE, "wr7f_addr_ack");
    write_byte(8'hA1, "wr7f_d0_ack");
    chk("wr7f_addr0", 32'(last_wr_addr), 32'h7F);
    write_byte(8'hB2, "wr7f_d1_ack");
    chk("wr7f_addr1", 32'(last_wr_addr), 32'h00);
    chk("wr7f_data1", 32'(last_wr_data), 32'hB2);
    i2c_stop();
    chk("wr7f_wr_cnt", 32'(wr_cnt), 32'd3);
    i2c_start();
    write_byte(8'hFF, "rd7f_addr_ack");
    read_byte(1'b0, rb);
    chk("rd7f_d0", 32'(rb), 32'hA1);
    read_byte(1'b1, rb);
    chk("rd7f_d1", 32'(rb), 32'hB2);
    chk("rd7f_rd_addr", 32'(last_rd_addr), 32'h00);
    i2c_stop();

    // STOP after five data bits discards the partial byte
    i2c_start();
    write_byte(8'h60, "wr30_addr_ack");
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    i2c_stop();
    chk("wr30_no_wr", 32'(wr_cnt), 32'd3);
    chk("wr30_idle", 32'(dut.state_q), 32'(IDLE));
    chk("wr30_sda_oe", 32'(sda_oe), 32'd0);
    i2c_start();
    write_byte(8'h61, "rd30_addr_ack");
    read_byte(1'b1, rb);
    i2c_stop();
    chk("rd30_data", 32'(rb), 32'h30);

    // Repeated START in the middle of a write data byte
    i2c_start();
    write_byte(8'h20, "rs_wr_addr_ack");
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    i2c_start();
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_state", 32'(dut.state_q), 32'(ADDR));
    write_byte(8'h21, "rs_rd_addr_ack");
    read_byte(1'b1, rb);
    i2c_stop();
    chk("rs_data", 32'(rb), 32'h10);
    chk("rs_no_wr", 32'(wr_cnt), 32'd3);

    // Asynchronous reset during the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 2);  // 0x04 -> address 0x02 write
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    chk("arst_pre_oe", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_sda_oe", 32'(sda_oe), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    i2c_start();
    write_byte(8'h25, "arst_rd12_ack");
    read_byte(1'b1, rb);
    i2c_stop();
    chk("arst_rd12_data", 32'(rb), 32'h12);
    i2c_start();
    write_byte(8'hFF, "arst_rd7f_ack");
    read_byte(1'b1, rb);
    i2c_stop();
    chk("arst_rd7f_data", 32'(rb), 32'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_mem.md
Name: i2c_target_mem

Overview:
- I2C target that answers the I2C master on the same bus.
- Consumes the master's 7-bit address + R/W byte, acknowledges it, then either stores the master's data byte or returns a stored byte.
- The 7-bit address field selects a location in an internal 2^ADDR_W x 8 register file; there is no separate device-address match.
- Sits directly downstream of the master on the shared SCL/SDA wires; a single system clock oversamples the bus.

Parameters:
- SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (minimum 2).
- ADDR_W, 7, address field width; the register file holds 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  reset, asynchronous, active-high.
- scl  in  1  bus clock from the master.
- sda_i  in  1  resolved SDA level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from detected START to detected STOP.
- wr_valid  out  1  one-cycle pulse when a received byte is committed to the register file.
- wr_addr  out  ADDR_W  location written; valid with wr_valid.
- wr_data  out  8  byte written; valid with wr_valid.
- rd_valid  out  1  one-cycle pulse when a byte is loaded for transmission.
- rd_addr  out  ADDR_W  location read; valid with rd_valid.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - Outputs: sda_oe=0, busy=0, wr_valid=0, rd_valid=0, wr_addr=0, wr_data=0, rd_addr=0.
  - State: state=IDLE, bit counter=0.
  - Register file: mem[i] = i[7:0].
  - Synchronizer flops reset to 1 (bus idle high).
- Input conditioning:
  - scl and sda_i pass through SYNC_STAGES flops plus one history flop.
  - Edge events are therefore seen SYNC_STAGES+1 clk after the pin changes.
- Bus events:
  - START: SDA falling while SCL high.
  - STOP: SDA rising while SCL high.
  - rise / fall: SCL edges.
- States and transitions:
  - IDLE: START -> ADDR with counter=0; busy=1.
  - ADDR: shift SDA MSB-first on each SCL rise. After the 8th rise, latch addr=bits[7:1] and rw=bit0. On the next SCL fall -> ACK_ADDR with sda_oe=1.
  - ACK_ADDR: hold sda_oe=1 through the 9th SCL high. On the 9th SCL fall:
    - rw=0: sda_oe=0 -> WR_DATA.
    - rw=1: load mem[addr], pulse rd_valid with rd_addr=addr, drive MSB (sda_oe = ~bit7) -> RD_DATA.
  - WR_DATA: shift 8 bits on SCL rises. On the following fall, sda_oe=1 -> ACK_DATA.
  - ACK_DATA: on the 9th fall, sda_oe=0. In that same cycle, pulse wr_valid (wr_addr=addr, wr_data=byte), write mem[addr], then addr = addr+1 mod 2^ADDR_W -> WR_DATA.
  - RD_DATA: update sda_oe on each SCL fall (sda_oe = ~current bit). After the 8th bit's fall, sda_oe=0 -> MACK.
  - MACK: sample SDA on the 9th rise.
    - ACK (0): addr+1 mod 2^ADDR_W; on the next fall load the next byte, pulse rd_valid -> RD_DATA.
    - NACK (1): -> WAIT_STOP.
  - WAIT_STOP: sda_oe=0; waits only for STOP or START.
- Global overrides, taking priority over the per-state transitions above:
  - STOP in any state -> IDLE, sda_oe=0, busy=0. A partial byte is discarded with no wr_valid.
  - START in any non-IDLE state (repeated start) -> ADDR, counter=0, busy stays 1, sda_oe=0.
- Simultaneous events:
  - START/STOP cannot coincide with SCL edges by protocol; if they do, START/STOP wins.
  - A bus write and the rd load of the same location never occur in the same cycle.
- Address wrap: 2^ADDR_W-1 increments to 0.
- sda_oe changes only in the cycle after a detected SCL fall, or on reset/STOP/START. It never changes while SCL is synchronously high, except the release on STOP/START.

Decomposition:
- Package i2c_pkg holds:
  - state enum: IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_DATA, RD_DATA, MACK, WAIT_STOP.
  - constants BYTE_BITS=8, ACK_BIT=9.
- Sub-module i2c_bus_sync:
  - Contains the synchronizers, history flops and event decode.
  - Outputs scl_rise, scl_fall, start_det, stop_det and the synchronized sda level.
  - The top module holds the FSM, counters, shift registers and register file.

Test Plan:
- Write: START, byte 0x24 (addr 0x12, W), data 0x5A, STOP -> target ACKs both 9th bits (sda_oe=1 across SCL high). One wr_valid with wr_addr=0x12, wr_data=0x5A. A later read of 0x12 returns 0x5A.
- Read after reset: START, 0x0F (addr 0x07, R), master NACK, STOP -> rd_valid with rd_addr=0x07; SDA carries 0x07 MSB-first; state goes WAIT_STOP then IDLE; busy drops on STOP.
- Burst with wrap: write to 0x7F with data 0xA1, 0xB2 -> wr_valid at 0x7F then 0x00. Reading 0x7F with master ACK then NACK returns 0xA1, 0xB2.
- STOP after 5 data bits of a write to 0x30 -> no wr_valid; mem[0x30] stays 0x30; state IDLE, sda_oe=0.
- Repeated START during WR_DATA, then 0x21 (addr 0x10, R) -> ADDR restarts; busy stays 1; returns 0x10.
- rst asserted mid-ACK_ADDR -> sda_oe=0 and busy=0 immediately, without a clk edge; register file contents back to mem[i]=i.
